stim_sequencer: RTL

STIM_SEQUENCER -- requirements
Module: stim_sequencer

---
 rtl/seeg_stim_pkg.sv | 22 ++
 rtl/stim_interval_counter.sv | 27 ++
 rtl/stim_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seeg_stim_pkg.sv
// Shared types and widths for the biphasic stimulation sequencer.
package seeg_stim_pkg;

    localparam int DUR_W = 16;
    localparam int MAG_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PHASE1,
        ST_GAP_PULSE,
        ST_PHASE2,
        ST_GAP_BIPULSE,
        ST_GAP_TRAIN,
        ST_RECOVERY
    } state_t;

    // A zero pulse width would make a phase vanish; it runs for one tick instead.
    function automatic logic [DUR_W-1:0] eff_pulse_len(input logic [DUR_W-1:0] len);
        return (len == '0) ? DUR_W'(1) : len;
    endfunction

endpackage

// File: rtl/stim_interval_counter.sv
// Tick down-counter timing the current sequencer state; expires on the Nth tick after load.
module stim_interval_counter
    import seeg_stim_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_tick_en,
    input  logic [DUR_W-1:0] i_count,
    output logic             o_expire
);

    logic [DUR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_count;
        end else if (i_tick_en && (r_count != '0)) begin
            r_count <= r_count - DUR_W'(1);
        end
    end

    assign o_expire = i_tick_en && (r_count == DUR_W'(1));

endmodule

// File: rtl/stim_sequencer.sv
// Biphasic pulse-train sequencer with finite and infinite modes.
// Optional charge-recovery window enabled by defining STIM_CHARGE_RECOVERY_EN.
module stim_sequencer
    import seeg_stim_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             finite_start,
    input  logic             infinite_start,
    input  logic             infinite_stop,
    input  logic [DUR_W-1:0] pulse_length,
    input  logic [DUR_W-1:0] inter_pulse_delay,
    input  logic [DUR_W-1:0] inter_bipulse_delay,
    input  logic [DUR_W-1:0] inter_train_delay,
    input  logic [DUR_W-1:0] bipulses_per_train,
    input  logic [DUR_W-1:0] train_count,
    input  logic [DUR_W-1:0] charge_recovery_time,
    input  logic [MAG_W-1:0] pulse_magnitude,
    input  logic             rising_edge_first,
    output logic             drive_pos,
    output logic             drive_neg,
    output logic             recover,
    output logic [MAG_W-1:0] magnitude,
    output logic             busy,
    output logic             done,
    output logic [DUR_W-1:0] train_idx,
    output logic [DUR_W-1:0] bipulse_idx
);

    state_t           r_state;
    state_t           w_next;
    state_t           w_end_state;
    logic [DUR_W-1:0] r_pulse_len, r_ipd, r_ibd, r_itd, r_bpt, r_tc;
    logic [MAG_W-1:0] r_amp;
    logic             r_ref, r_inf, r_stop;
    logic             w_accept, w_accept_inf, w_stop, w_expire, w_load;
    logic             w_last_bip, w_more_trains, w_p2_exit, w_ref;
    logic [MAG_W-1:0] w_amp;
    logic [DUR_W-1:0] w_load_val;

`ifdef STIM_CHARGE_RECOVERY_EN
    logic [DUR_W-1:0] r_crt;
    assign w_end_state = (r_crt != '0) ? ST_RECOVERY : ST_IDLE;
`else
    logic w_unused_crt;
    assign w_unused_crt = ^charge_recovery_time;
    assign w_end_state  = ST_IDLE;
    assign recover      = 1'b0;
`endif

    // A stop pulse counts in the same cycle it arrives, so a pending PHASE2 exit sees it.
    assign w_stop        = r_stop | (r_inf & infinite_stop & (r_state != ST_IDLE));
    assign w_last_bip    = (r_bip_idx_eq_last());
    assign w_more_trains = r_inf | (train_idx != r_tc - DUR_W'(1));
    assign w_p2_exit     = (r_state == ST_PHASE2) && w_expire;
    assign w_load        = (w_next != r_state);
    assign w_ref         = w_accept ? rising_edge_first : r_ref;
    assign w_amp         = w_accept ? pulse_magnitude : r_amp;

    function automatic logic r_bip_idx_eq_last();
        return bipulse_idx == (r_bpt - DUR_W'(1));
    endfunction

    stim_interval_counter u_interval (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_tick_en (tick_en),
        .i_count   (w_load_val),
        .o_expire  (w_expire)
    );

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_accept_inf = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (finite_start) begin
                    if ((bipulses_per_train != '0) && (train_count != '0)) begin
                        w_accept = 1'b1;
                        w_next   = ST_PHASE1;
                    end
                end else if (infinite_start && (bipulses_per_train != '0)) begin
                    w_accept     = 1'b1;
                    w_accept_inf = 1'b1;
                    w_next       = ST_PHASE1;
                end
            end
            ST_PHASE1: begin
                if (w_expire) w_next = (r_ipd != '0) ? ST_GAP_PULSE : ST_PHASE2;
            end
            ST_GAP_PULSE: begin
                if (w_expire) w_next = ST_PHASE2;
            end
            ST_PHASE2: begin
                if (w_expire) begin
                    if (w_stop)             w_next = w_end_state;
                    else if (!w_last_bip)   w_next = (r_ibd != '0) ? ST_GAP_BIPULSE : ST_PHASE1;
                    else if (w_more_trains) w_next = (r_itd != '0) ? ST_GAP_TRAIN : ST_PHASE1;
                    else                    w_next = w_end_state;
                end
            end
            ST_GAP_BIPULSE, ST_GAP_TRAIN: begin
                if (w_stop)        w_next = w_end_state;
                else if (w_expire) w_next = ST_PHASE1;
            end
            ST_RECOVERY: begin
                if (w_expire) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The counter is loaded with the duration of the state being entered.
    always_comb begin
        w_load_val = '0;
        case (w_next)
            ST_PHASE1:      w_load_val = eff_pulse_len((r_state == ST_IDLE) ? pulse_length : r_pulse_len);
            ST_PHASE2:      w_load_val = eff_pulse_len(r_pulse_len);
            ST_GAP_PULSE:   w_load_val = r_ipd;
            ST_GAP_BIPULSE: w_load_val = r_ibd;
            ST_GAP_TRAIN:   w_load_val = r_itd;
`ifdef STIM_CHARGE_RECOVERY_EN
            ST_RECOVERY:    w_load_val = r_crt;
`endif
            default:        w_load_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pulse_len <= pulse_length;
            r_ipd       <= inter_pulse_delay;
            r_ibd       <= inter_bipulse_delay;
            r_itd       <= inter_train_delay;
            r_bpt       <= bipulses_per_train;
            r_tc        <= train_count;
            r_amp       <= pulse_magnitude;
            r_ref       <= rising_edge_first;
`ifdef STIM_CHARGE_RECOVERY_EN
            r_crt       <= charge_recovery_time;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_inf       <= 1'b0;
            r_stop      <= 1'b0;
            train_idx   <= '0;
            bipulse_idx <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            drive_pos   <= 1'b0;
            drive_neg   <= 1'b0;
            magnitude   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_inf       <= w_accept_inf;
                r_stop      <= 1'b0;
                train_idx   <= '0;
                bipulse_idx <= '0;
            end else begin
                if (w_next == ST_IDLE) r_stop <= 1'b0;
                else if (w_stop)       r_stop <= 1'b1;
                if (w_p2_exit) begin
                    if (w_last_bip) begin
                        bipulse_idx <= '0;
                        train_idx   <= train_idx + DUR_W'(1);
                    end else begin
                        bipulse_idx <= bipulse_idx + DUR_W'(1);
                    end
                end
            end
            busy      <= (w_next != ST_IDLE);
            done      <= (w_next == ST_IDLE) && (r_state != ST_IDLE);
            drive_pos <= ((w_next == ST_PHASE1) && w_ref) || ((w_next == ST_PHASE2) && !w_ref);
            drive_neg <= ((w_next == ST_PHASE1) && !w_ref) || ((w_next == ST_PHASE2) && w_ref);
            magnitude <= ((w_next == ST_PHASE1) || (w_next == ST_PHASE2)) ? w_amp : '0;
        end
    end

`ifdef STIM_CHARGE_RECOVERY_EN
    always_ff @(posedge clk) begin
        if (rst) recover <= 1'b0;
        else     recover <= (w_next == ST_RECOVERY);
    end
`endif

endmodule
